lam_xt_scan_step2: RTL and testbench

Step-2 consumer of the joined lambda/xt stream: accepts one TILE_SIZE-lane beat per handshake (lambda in Q0.16, xt in Q8.8) and applies the per-channel gated recurrence h = lam·h_prev + (1−lam)·x. It keeps one hidden-state word per channel, D/TILE_SIZE tiles per token, and emits the updated hidden-state tile on a valid/ready stream. It sits directly downstream of the lam/xt join, on the receiving end of its out_valid/out_ready interface.

---
 rtl/scan_pkg.sv | 26 ++
 rtl/scan_state_regfile.sv | 52 +++++
 rtl/lam_xt_scan_step2.sv | 147 ++++++++++++++
 tb/tb_lam_xt_scan_step2.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and per-lane arithmetic for the lambda/xt gated scan (step 2).
// The SCAN_SOF_CLEAR_EN macro is consumed by the files that import this package.
package scan_pkg;

    localparam int LANES = 4;
    localparam int RND   = 32768;

    typedef logic        [15:0] lam_t;
    typedef logic signed [15:0] q88_t;

    typedef q88_t [LANES-1:0] tile_q88_t;
    typedef lam_t [LANES-1:0] tile_lam_t;

    // h = lam*h + (1-lam)*x with round-half-up; the weights sum to 1.0, so the
    // result is a convex combination and always fits back into Q8.8.
    function automatic q88_t scan_lane(input lam_t lam, input q88_t h, input q88_t x);
        logic signed [17:0] w_h;
        logic signed [17:0] w_x;
        logic signed [33:0] t;
        w_h = signed'({2'b00, lam});
        w_x = 18'sd65536 - w_h;
        t   = 34'(w_h) * 34'(h) + 34'(w_x) * 34'(x) + 34'(RND);
        return q88_t'(t >>> 16);
    endfunction

endpackage

// File: rtl/scan_state_regfile.sv
// Per-tile hidden-state store with one forwarded read port and one write port.
// SCAN_SOF_CLEAR_EN adds a start-of-sequence clear of entries 1..NT-1.
module scan_state_regfile
    import scan_pkg::*;
#(
    parameter int TILE_SIZE = 4,
    parameter int NT        = 64,
    parameter int TIDX_W    = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [TIDX_W-1:0]           rd_idx,
    output q88_t [TILE_SIZE-1:0]        rd_data,
    input  logic                        wr_en,
    input  logic [TIDX_W-1:0]           wr_idx,
    input  q88_t [TILE_SIZE-1:0]        wr_data
`ifdef SCAN_SOF_CLEAR_EN
    ,
    input  logic                        clr
`endif
);

    q88_t [TILE_SIZE-1:0] mem [NT];

    // NOTE: the state array is reset on purpose -- a fresh sequence must start
    // from h = 0 -- so it stays in flops rather than an inferred RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NT; i++) mem[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop update ordered
            // against the same pre-edge values, as for real hardware.
            if (wr_en) mem[wr_idx] <= wr_data;
`ifdef SCAN_SOF_CLEAR_EN
            // The clear wins over a late write from the previous token.
            if (clr) begin
                for (int i = 1; i < NT; i++) mem[i] <= '0;
            end
`endif
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves rd_data unassigned (no latch).
        rd_data = mem[rd_idx];
        if (wr_en && (wr_idx == rd_idx)) rd_data = wr_data;
`ifdef SCAN_SOF_CLEAR_EN
        if (clr) rd_data = '0;
`endif
    end

endmodule

// File: rtl/lam_xt_scan_step2.sv
// Two-stage gated scan h = lam*h_prev + (1-lam)*x over tiles of a token.
// Optional macro SCAN_SOF_CLEAR_EN adds the sof port and start-of-sequence clear.
module lam_xt_scan_step2
    import scan_pkg::*;
#(
    parameter int TILE_SIZE  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int D          = 256,
    parameter int TIDX_W     = ((D / TILE_SIZE) > 1) ? $clog2(D / TILE_SIZE) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] in_lam_vec,
    input  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] in_xt_vec,
`ifdef SCAN_SOF_CLEAR_EN
    input  logic                                 sof,
`endif
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] out_h_vec,
    output logic [TIDX_W-1:0]                    out_tile_idx,
    output logic                                 out_last,
    output logic [31:0]                          tok_cnt
);

    localparam int NT = D / TILE_SIZE;
    localparam logic [TIDX_W-1:0] LAST_IDX = TIDX_W'(NT - 1);

    if ((D % TILE_SIZE) != 0 || NT < 1 || DATA_WIDTH != 16) begin : g_cfg_err
        $error("lam_xt_scan_step2: D must be a nonzero multiple of TILE_SIZE, DATA_WIDTH 16");
    end

    logic                  accept;
    logic                  adv1;
    logic                  pop;
    logic [TIDX_W-1:0]     in_idx;
    logic [TIDX_W-1:0]     beat_idx;
    q88_t [TILE_SIZE-1:0]  h_prev;

    logic                  v1;
    lam_t [TILE_SIZE-1:0]  lam1;
    q88_t [TILE_SIZE-1:0]  x1;
    q88_t [TILE_SIZE-1:0]  h1;
    logic [TIDX_W-1:0]     idx1;
    q88_t [TILE_SIZE-1:0]  h_new;

    logic                  v2;
    q88_t [TILE_SIZE-1:0]  h2;
    logic [TIDX_W-1:0]     idx2;
    logic                  last2;

    assign adv1     = v1 && (!v2 || out_ready);
    assign in_ready = !v1 || adv1;
    assign accept   = in_valid && in_ready;
    assign pop      = v2 && out_ready;

`ifdef SCAN_SOF_CLEAR_EN
    logic sof_clr;
    assign sof_clr  = accept && sof;
    assign beat_idx = sof_clr ? '0 : in_idx;
`else
    assign beat_idx = in_idx;
`endif

    scan_state_regfile #(
        .TILE_SIZE (TILE_SIZE),
        .NT        (NT),
        .TIDX_W    (TIDX_W)
    ) u_state (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_idx  (beat_idx),
        .rd_data (h_prev),
        .wr_en   (adv1),
        .wr_idx  (idx1),
        .wr_data (h_new)
`ifdef SCAN_SOF_CLEAR_EN
        ,
        .clr     (sof_clr)
`endif
    );

    always_comb begin
        h_new = '0;
        for (int i = 0; i < TILE_SIZE; i++) h_new[i] = scan_lane(lam1[i], h1[i], x1[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_idx <= '0;
        end else if (accept) begin
            in_idx <= (beat_idx == LAST_IDX) ? '0 : beat_idx + TIDX_W'(1);
        end
    end

    // S1: operands plus the (possibly forwarded) previous state of this tile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            lam1 <= '0;
            x1   <= '0;
            h1   <= '0;
            idx1 <= '0;
        end else if (accept) begin
            v1   <= 1'b1;
            lam1 <= in_lam_vec;
            x1   <= in_xt_vec;
            h1   <= h_prev;
            idx1 <= beat_idx;
        end else if (adv1) begin
            v1   <= 1'b0;
        end
    end

    // S2: output register, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            h2    <= '0;
            idx2  <= '0;
            last2 <= 1'b0;
        end else if (adv1) begin
            v2    <= 1'b1;
            h2    <= h_new;
            idx2  <= idx1;
            last2 <= (idx1 == LAST_IDX);
        end else if (pop) begin
            v2    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_cnt <= '0;
        end else if (pop && last2) begin
            tok_cnt <= tok_cnt + 32'd1;
        end
    end

    assign out_valid    = v2;
    assign out_h_vec    = h2;
    assign out_tile_idx = idx2;
    assign out_last     = last2;

endmodule

// File: tb/tb_lam_xt_scan_step2.sv
// Scoreboard bench: instance 0 has D=8 (two tiles per token), instance 1 has D=4 (one tile).
// Optional macro SCAN_SOF_CLEAR_EN enables the sof-clear scenario.
module tb_lam_xt_scan_step2;

    localparam int TS = 4;
    localparam int DW = 16;

    typedef logic [TS-1:0][DW-1:0] vec_t;
    typedef struct {
        vec_t h;
        logic idx;
        logic last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic        out_last  [2];
    logic        sof       [2];
    vec_t        lam_v     [2];
    vec_t        xt_v      [2];
    vec_t        h_v       [2];
    logic [0:0]  tidx      [2];
    logic [31:0] tok       [2];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   acc_cnt [2];
    exp_t sb0 [$];
    exp_t sb1 [$];

    always #5 clk = ~clk;

    lam_xt_scan_step2 #(.TILE_SIZE(TS), .DATA_WIDTH(DW), .D(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_lam_vec(lam_v[0]), .in_xt_vec(xt_v[0]),
`ifdef SCAN_SOF_CLEAR_EN
        .sof(sof[0]),
`endif
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_h_vec(h_v[0]), .out_tile_idx(tidx[0]),
        .out_last(out_last[0]), .tok_cnt(tok[0])
    );

    lam_xt_scan_step2 #(.TILE_SIZE(TS), .DATA_WIDTH(DW), .D(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_lam_vec(lam_v[1]), .in_xt_vec(xt_v[1]),
`ifdef SCAN_SOF_CLEAR_EN
        .sof(sof[1]),
`endif
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_h_vec(h_v[1]), .out_tile_idx(tidx[1]),
        .out_last(out_last[1]), .tok_cnt(tok[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t splat(input logic [15:0] v);
        return {v, v, v, v};
    endfunction

    // Holds the beat until it is accepted, then records the expected response.
    task automatic send(input int k, input vec_t lam, input vec_t x, input logic s,
                        input vec_t eh, input logic eidx, input logic elast);
        bit   done = 0;
        int   waited = 0;
        exp_t e;
        lam_v[k] = lam; xt_v[k] = x; sof[k] = s; in_valid[k] = 1'b1;
        while (!done && waited < 200) begin
            @(negedge clk);
            done = in_ready[k];
            @(posedge clk);
            waited++;
        end
        if (!done) begin
            check("send_timeout", 64'd0, 64'd1);
        end else begin
            e.h = eh; e.idx = eidx; e.last = elast;
            if (k == 0) sb0.push_back(e); else sb1.push_back(e);
            acc_cnt[k]++;
        end
        #1;
        in_valid[k] = 1'b0;
        sof[k] = 1'b0;
    endtask

    task automatic monitor(input int k);
        bit   stalled = 0;
        vec_t ph;
        logic pidx;
        logic plast;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    check("hold_valid", 64'(out_valid[k]), 64'd1);
                    check("hold_h", h_v[k], ph);
                    check("hold_idx_last", {tidx[k], out_last[k]}, {pidx, plast});
                end
                if (out_valid[k] && out_ready[k]) begin
                    if ((k == 0 && sb0.size() == 0) || (k == 1 && sb1.size() == 0)) begin
                        check("unexpected_output", 64'd1, 64'd0);
                    end else begin
                        e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
                        check("out_h_vec", h_v[k], e.h);
                        check("out_tile_idx", 64'(tidx[k]), 64'(e.idx));
                        check("out_last", 64'(out_last[k]), 64'(e.last));
                    end
                end
                stalled = out_valid[k] && !out_ready[k];
                ph = h_v[k]; pidx = tidx[k]; plast = out_last[k];
            end
        end
    endtask

    task automatic wait_drain(input int k);
        int n = 0;
        while (((k == 0) ? sb0.size() : sb1.size()) != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) check("drain_timeout", 64'd0, 64'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb0.delete();
        sb1.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_out_valid", 64'(out_valid[k]), 64'd0);
            check("rst_in_ready", 64'(in_ready[k]), 64'd1);
            check("rst_h_idx_last", {h_v[k], tidx[k], out_last[k]}, 64'd0);
            check("rst_tok_cnt", 64'(tok[k]), 64'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial fork
        monitor(0);
        monitor(1);
    join_none

    initial begin : main
        vec_t x2;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; out_ready[k] = 1'b1; sof[k] = 1'b0;
            lam_v[k] = '0; xt_v[k] = '0; acc_cnt[k] = 0;
        end
        do_reset();

        // lam = 0 passes x straight through, including negative lanes.
        send(0, splat(16'h0000), splat(16'h0100), 1'b0, splat(16'h0100), 1'b0, 1'b0);
        send(0, splat(16'h0000), {16'hFF00, 16'h7FFF, 16'h0080, 16'h0100}, 1'b0,
             {16'hFF00, 16'h7FFF, 16'h0080, 16'h0100}, 1'b1, 1'b1);
        wait_drain(0);
        check("tok_cnt_after_1", 64'(tok[0]), 64'd1);

        // lam = 0.5 over three tokens; lane 3 exercises rounding of negatives.
        do_reset();
        x2 = {16'hFF00, 16'h0200, 16'h0200, 16'h0200};
        for (int t = 0; t < 3; t++) begin
            vec_t eh;
            case (t)
                0: eh = {16'hFF80, 16'h0100, 16'h0100, 16'h0100};
                1: eh = {16'hFF40, 16'h0180, 16'h0180, 16'h0180};
                default: eh = {16'hFF20, 16'h01C0, 16'h01C0, 16'h01C0};
            endcase
            send(0, splat(16'h8000), x2, 1'b0, eh, 1'b0, 1'b0);
            send(0, splat(16'h8000), x2, 1'b0, eh, 1'b1, 1'b1);
        end
        wait_drain(0);
        check("tok_cnt_after_3", 64'(tok[0]), 64'd3);

        // Single-tile token, back-to-back: only correct with forwarding.
        send(1, splat(16'h8000), splat(16'h0400), 1'b0, splat(16'h0200), 1'b0, 1'b1);
        send(1, splat(16'h8000), splat(16'h0400), 1'b0, splat(16'h0300), 1'b0, 1'b1);
        send(1, splat(16'h8000), splat(16'h0400), 1'b0, splat(16'h0380), 1'b0, 1'b1);
        wait_drain(1);
        check("tok_cnt_nt1", 64'(tok[1]), 64'd3);

        // Backpressure: two beats in flight, the rest wait, none lost or doubled.
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        acc_cnt[0] = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    logic [15:0] xv;
                    xv = 16'(16'h0011 * (i + 1));
                    send(0, splat(16'h0000), splat(xv), 1'b0, splat(xv), 1'(i % 2), 1'(i % 2));
                end
            end
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready_low", 64'(in_ready[0]), 64'd0);
                check("bp_accepts", 64'(acc_cnt[0]), 64'd2);
                check("bp_out_valid", 64'(out_valid[0]), 64'd1);
                @(posedge clk);
                #1;
                out_ready[0] = 1'b1;
            end
        join
        wait_drain(0);
        check("bp_total_accepts", 64'(acc_cnt[0]), 64'd4);
        check("tok_cnt_after_bp", 64'(tok[0]), 64'd5);

        // Reset mid-token discards the in-flight beat and restarts at tile 0.
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        send(0, splat(16'h0000), splat(16'h0300), 1'b0, splat(16'h0300), 1'b0, 1'b0);
        @(posedge clk);
        do_reset();
        out_ready[0] = 1'b1;
        send(0, splat(16'hC000), splat(16'h0100), 1'b0, splat(16'h0040), 1'b0, 1'b0);
        wait_drain(0);
        check("tok_cnt_partial", 64'(tok[0]), 64'd0);

`ifdef SCAN_SOF_CLEAR_EN
        // sof mid-token restarts at tile 0 and zeroes the remaining tiles.
        do_reset();
        send(0, splat(16'h0000), splat(16'h7F00), 1'b0, splat(16'h7F00), 1'b0, 1'b0);
        send(0, splat(16'h0000), splat(16'h7F00), 1'b0, splat(16'h7F00), 1'b1, 1'b1);
        send(0, splat(16'h0000), splat(16'h7F00), 1'b0, splat(16'h7F00), 1'b0, 1'b0);
        send(0, splat(16'hFFFF), splat(16'h0000), 1'b1, splat(16'h0000), 1'b0, 1'b0);
        send(0, splat(16'hFFFF), splat(16'h0000), 1'b0, splat(16'h0000), 1'b1, 1'b1);
        wait_drain(0);
        check("tok_cnt_sof", 64'(tok[0]), 64'd2);
`endif

        wait_drain(0);
        wait_drain(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
